// File: rtl/voice_scheduler_pkg.sv
// Shared constants and types for the drum voice scheduler: default geometry,
// voice-to-ROM mapping and the mix-frame state encoding.
package voice_scheduler_pkg;

    localparam int unsigned DEF_NUM_VOICES = 4;
    localparam int unsigned DEF_ADDR_W     = 13;
    localparam int unsigned DEF_DATA_W     = 8;
    localparam int unsigned DEF_SAMPLE_LEN = 8192;

    // Voice index doubles as the ROM select in the shared bank.
    typedef enum logic [1:0] {
        VOICE_KICK  = 2'd0,
        VOICE_SNARE = 2'd1,
        VOICE_HAT   = 2'd2,
        VOICE_CLAP  = 2'd3
    } voice_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } state_e;

endpackage

// File: rtl/voice_scheduler_voice_counter.sv
// Per-voice playback state: trigger edge capture, pending flag, active flag and
// sample address; exposes the address the voice will hold after this cycle.
module voice_scheduler_voice_counter
    import voice_scheduler_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned SAMPLE_LEN = DEF_SAMPLE_LEN
) (
    input  logic              clk_i,
    input  logic              resetn_i,
    input  logic              start_i,
    input  logic              step_i,
    input  logic              trig_i,
    output logic [ADDR_W-1:0] addr_nxt_c_o,
    output logic              active_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SAMPLE_LEN - 1);

    logic              trig_q;
    logic              pending_q, pending_d;
    logic              active_q, active_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              trig_rise_c;
    logic              launch_c;

    assign trig_rise_c = trig_i & ~trig_q;
    // An edge arriving in the same cycle as the frame start still launches.
    assign launch_c    = start_i & (pending_q | trig_rise_c);

    always_comb begin
        addr_d    = addr_q;
        active_d  = active_q;
        pending_d = pending_q | trig_rise_c;
        if (launch_c) begin
            addr_d    = '0;
            active_d  = 1'b1;
            pending_d = 1'b0;
        end else if (step_i && active_q) begin
            if (addr_q == LAST_ADDR) begin
                active_d = 1'b0;
            end else begin
                addr_d = addr_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            trig_q    <= 1'b0;
            pending_q <= 1'b0;
            active_q  <= 1'b0;
            addr_q    <= '0;
        end else begin
            trig_q    <= trig_i;
            pending_q <= pending_d;
            active_q  <= active_d;
            addr_q    <= addr_d;
        end
    end

    assign addr_nxt_c_o = addr_d;
    assign active_o     = active_q;

endmodule

// File: rtl/voice_scheduler.sv
// Time-multiplexes one shared drum-sample ROM port across all voices each
// sample tick, accumulating their samples into one saturated mix.
module voice_scheduler
    import voice_scheduler_pkg::*;
#(
    parameter int unsigned NUM_VOICES = DEF_NUM_VOICES,
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned SAMPLE_LEN = DEF_SAMPLE_LEN
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          sample_tick,
    input  logic [NUM_VOICES-1:0]         trig,
    input  logic [NUM_VOICES-1:0]         mute,
    output logic [$clog2(NUM_VOICES)-1:0] rom_sel,
    output logic [ADDR_W-1:0]             rom_addr,
    input  logic [DATA_W-1:0]             rom_q,
    output logic [DATA_W-1:0]             mix_out,
    output logic                          mix_valid,
    output logic [NUM_VOICES-1:0]         active,
    output logic                          busy,
    output logic                          overrun
);

    localparam int unsigned SEL_W    = $clog2(NUM_VOICES);
    localparam int unsigned ACC_W    = DATA_W + SEL_W;
    localparam int unsigned LAST_IDX = NUM_VOICES - 1;
    localparam logic [ACC_W-1:0] MIX_MAX = ACC_W'((1 << DATA_W) - 1);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   idx_q, idx_d, idx_nxt;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   rd_c, sum_c;
    logic               gate_q, gate_d;
    logic [SEL_W-1:0]   rom_sel_q, rom_sel_d;
    logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
    logic [DATA_W-1:0]  mix_out_q, mix_out_d;
    logic               mix_valid_q, mix_valid_d;
    logic               busy_q, busy_d;
    logic               overrun_q, overrun_d;
    logic               start_c;
    logic [NUM_VOICES-1:0] step_c;
    logic [NUM_VOICES-1:0] active_w;
    logic [ADDR_W-1:0]  addr_nxt_c [NUM_VOICES];

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
        voice_scheduler_voice_counter #(
            .ADDR_W     (ADDR_W),
            .SAMPLE_LEN (SAMPLE_LEN)
        ) u_voice (
            .clk_i        (clk),
            .resetn_i     (resetn),
            .start_i      (start_c),
            .step_i       (step_c[v]),
            .trig_i       (trig[v]),
            .addr_nxt_c_o (addr_nxt_c[v]),
            .active_o     (active_w[v])
        );
    end

    // ROM select/address are loaded one cycle ahead so they are stable
    // throughout the issue cycle of the voice they belong to.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        gate_d      = gate_q;
        rom_sel_d   = rom_sel_q;
        rom_addr_d  = rom_addr_q;
        mix_out_d   = mix_out_q;
        mix_valid_d = 1'b0;
        start_c     = 1'b0;
        step_c      = '0;
        overrun_d   = overrun_q | (sample_tick & (state_q != ST_IDLE));
        idx_nxt     = idx_q + SEL_W'(1);
        rd_c        = gate_q ? ACC_W'(rom_q) : '0;
        sum_c       = acc_q + rd_c;

        unique case (state_q)
            ST_IDLE: begin
                if (sample_tick) begin
                    start_c    = 1'b1;
                    idx_d      = '0;
                    acc_d      = '0;
                    rom_sel_d  = '0;
                    rom_addr_d = addr_nxt_c[0];
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                step_c[idx_q] = 1'b1;
                gate_d        = active_w[idx_q] & ~mute[idx_q];
                // rom_q in the first issue cycle belongs to no voice of this frame
                if (idx_q != '0) begin
                    acc_d = sum_c;
                end
                if (idx_q == SEL_W'(LAST_IDX)) begin
                    state_d = ST_DRAIN;
                end else begin
                    idx_d      = idx_nxt;
                    rom_sel_d  = idx_nxt;
                    rom_addr_d = addr_nxt_c[idx_nxt];
                end
            end
            ST_DRAIN: begin
                acc_d       = sum_c;
                mix_out_d   = (sum_c > MIX_MAX) ? '1 : sum_c[DATA_W-1:0];
                mix_valid_d = 1'b1;
                state_d     = ST_OUT;
            end
            ST_OUT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            acc_q       <= '0;
            gate_q      <= 1'b0;
            rom_sel_q   <= '0;
            rom_addr_q  <= '0;
            mix_out_q   <= '0;
            mix_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            gate_q      <= gate_d;
            rom_sel_q   <= rom_sel_d;
            rom_addr_q  <= rom_addr_d;
            mix_out_q   <= mix_out_d;
            mix_valid_q <= mix_valid_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rom_sel   = rom_sel_q;
    assign rom_addr  = rom_addr_q;
    assign mix_out   = mix_out_q;
    assign mix_valid = mix_valid_q;
    assign active    = active_w;
    assign busy      = busy_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_voice_scheduler.sv
// Scoreboard bench for voice_scheduler: a frame-level playback model predicts
// ROM reads and mixed samples; a monitor compares them as the DUT presents them.
module tb_voice_scheduler;

    localparam int NV  = 4;
    localparam int AW  = 13;
    localparam int DW  = 8;
    localparam int LEN = 20;

    logic          clk         = 1'b0;
    logic          resetn      = 1'b0;
    logic          sample_tick = 1'b0;
    logic [NV-1:0] trig        = '0;
    logic [NV-1:0] mute        = '0;
    logic [1:0]    rom_sel;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_q       = '0;
    logic [DW-1:0] mix_out;
    logic          mix_valid;
    logic [NV-1:0] active;
    logic          busy;
    logic          overrun;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct { int cyc; int mix; int act; } mix_exp_t;
    typedef struct { int cyc; int sel; int addr; } rd_exp_t;
    mix_exp_t mq[$];
    rd_exp_t  rq[$];

    // Playback model state
    int m_addr [NV];
    bit m_act  [NV];
    bit m_pend [NV];
    bit m_tprev[NV];
    int m_acc;
    int m_fs;
    bit m_fsv;
    bit m_ovr;

    voice_scheduler #(
        .NUM_VOICES (NV),
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .SAMPLE_LEN (LEN)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .sample_tick (sample_tick),
        .trig        (trig),
        .mute        (mute),
        .rom_sel     (rom_sel),
        .rom_addr    (rom_addr),
        .rom_q       (rom_q),
        .mix_out     (mix_out),
        .mix_valid   (mix_valid),
        .active      (active),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Registered ROM bank: data = {voice, addr[5:0]}
    always @(posedge clk) rom_q <= {rom_sel, rom_addr[5:0]};

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, got, exp);
        end
    endtask

    // Monitor: consumes expectations as the DUT presents reads and mixes.
    always @(negedge clk) begin
        mix_exp_t e;
        rd_exp_t  r;
        if (mix_valid === 1'b1) begin
            if (mq.size() == 0) begin
                chk("unexpected_mix_valid", 1, 0);
            end else begin
                e = mq.pop_front();
                chk("mix_latency", cyc, e.cyc);
                chk("mix_out", int'(mix_out), e.mix);
                chk("active_at_mix", int'(active), e.act);
            end
        end else if (mq.size() != 0 && mq[0].cyc <= cyc) begin
            e = mq.pop_front();
            chk("mix_valid_missing", 0, 1);
        end
        while (rq.size() != 0 && rq[0].cyc <= cyc) begin
            r = rq.pop_front();
            if (r.cyc == cyc) begin
                chk("rom_sel", int'(rom_sel), r.sel);
                chk("rom_addr", int'(rom_addr), r.addr);
            end else begin
                chk("rom_read_missed", 0, 1);
            end
        end
    end

    task automatic model_reset();
        for (int v = 0; v < NV; v++) begin
            m_addr[v]  = 0;
            m_act[v]   = 1'b0;
            m_pend[v]  = 1'b0;
            m_tprev[v] = 1'b0;
        end
        m_acc = 0;
        m_fs  = 0;
        m_fsv = 1'b0;
        m_ovr = 1'b0;
        mq.delete();
        rq.delete();
    endtask

    // One clock cycle: check status outputs, drive inputs, advance the model.
    task automatic do_cycle(input bit t, input logic [NV-1:0] tr, input logic [NV-1:0] mu, input bit rn);
        bit       busy_m;
        int       v;
        int       av;
        mix_exp_t e;
        rd_exp_t  r;
        @(negedge clk);
        #1;
        busy_m = m_fsv && (cyc >= m_fs + 1) && (cyc <= m_fs + NV + 2);
        chk("busy", int'(busy), int'(busy_m));
        chk("overrun", int'(overrun), int'(m_ovr));
        sample_tick = t;
        trig        = tr;
        mute        = mu;
        resetn      = rn;
        if (!rn) begin
            model_reset();
        end else begin
            if (m_fsv && (cyc >= m_fs + 1) && (cyc <= m_fs + NV)) begin
                v = cyc - m_fs - 1;
                if (m_act[v] && !mu[v]) m_acc += v * 64 + (m_addr[v] % 64);
                if (m_act[v]) begin
                    if (m_addr[v] == LEN - 1) m_act[v] = 1'b0;
                    else m_addr[v]++;
                end
                if (v == NV - 1) begin
                    av = 0;
                    for (int i = 0; i < NV; i++) if (m_act[i]) av += (1 << i);
                    e.cyc = cyc + 2;
                    e.mix = (m_acc > 255) ? 255 : m_acc;
                    e.act = av;
                    mq.push_back(e);
                end
            end
            for (int i = 0; i < NV; i++) if (tr[i] && !m_tprev[i]) m_pend[i] = 1'b1;
            if (t) begin
                if (busy_m) begin
                    m_ovr = 1'b1;
                end else begin
                    m_fs  = cyc;
                    m_fsv = 1'b1;
                    m_acc = 0;
                    for (int i = 0; i < NV; i++) begin
                        if (m_pend[i]) begin
                            m_addr[i] = 0;
                            m_act[i]  = 1'b1;
                            m_pend[i] = 1'b0;
                        end
                        r.cyc  = cyc + 1 + i;
                        r.sel  = i;
                        r.addr = m_addr[i];
                        rq.push_back(r);
                    end
                end
            end
            for (int i = 0; i < NV; i++) m_tprev[i] = tr[i];
        end
    endtask

    initial begin
        logic [NV-1:0] rtr;
        logic [NV-1:0] rmu;
        bit            rt;
        bit            rrn;

        model_reset();
        do_cycle(1'b0, '0, '0, 1'b0);
        do_cycle(1'b0, '0, '0, 1'b0);
        do_cycle(1'b0, '0, '0, 1'b1);
        chk("rst_rom_sel", int'(rom_sel), 0);
        chk("rst_rom_addr", int'(rom_addr), 0);
        chk("rst_mix_out", int'(mix_out), 0);
        chk("rst_mix_valid", int'(mix_valid), 0);
        chk("rst_active", int'(active), 0);

        // Single voice 0, first frame reads address 0
        do_cycle(1'b1, 4'b0001, '0, 1'b1);
        repeat (8) do_cycle(1'b0, 4'b0001, '0, 1'b1);
        chk("voice0_first_mix", int'(mix_out), 0);

        // All voices from address 0; sixth frame sums 404 and saturates
        do_cycle(1'b0, 4'b0000, '0, 1'b1);
        for (int f = 0; f < 6; f++) begin
            do_cycle(1'b1, 4'b1111, '0, 1'b1);
            repeat (7) do_cycle(1'b0, 4'b1111, '0, 1'b1);
        end
        chk("saturated_mix", int'(mix_out), 255);

        // Voice 2 muted for two frames, then unmuted
        for (int f = 0; f < 4; f++) begin
            rmu = (f < 2) ? 4'b0100 : 4'b0000;
            do_cycle(1'b1, 4'b1111, rmu, 1'b1);
            repeat (7) do_cycle(1'b0, 4'b1111, rmu, 1'b1);
        end

        // Tick two cycles after a tick is dropped; overrun sticks
        do_cycle(1'b1, 4'b1111, '0, 1'b1);
        do_cycle(1'b0, 4'b1111, '0, 1'b1);
        do_cycle(1'b1, 4'b1111, '0, 1'b1);
        repeat (7) do_cycle(1'b0, 4'b1111, '0, 1'b1);
        chk("overrun_sticky", int'(overrun), 1);

        // Reset in the middle of the issue phase discards the frame
        do_cycle(1'b1, 4'b1111, '0, 1'b1);
        do_cycle(1'b0, 4'b1111, '0, 1'b1);
        do_cycle(1'b0, 4'b1111, '0, 1'b0);
        do_cycle(1'b0, 4'b1111, '0, 1'b1);
        chk("midrst_mix_out", int'(mix_out), 0);
        chk("midrst_active", int'(active), 0);
        chk("midrst_mix_valid", int'(mix_valid), 0);
        repeat (8) do_cycle(1'b0, 4'b1111, '0, 1'b1);

        // Randomized traffic: ticks, trigger toggles, mute toggles, rare resets
        rtr = 4'b1111;
        rmu = '0;
        repeat (4000) begin
            rt  = ($urandom_range(0, 7) == 0);
            rrn = ($urandom_range(0, 499) != 0);
            for (int i = 0; i < NV; i++) begin
                if ($urandom_range(0, 11) == 0) rtr[i] = ~rtr[i];
                if ($urandom_range(0, 9) == 0)  rmu[i] = ~rmu[i];
            end
            do_cycle(rt, rtr, rmu, rrn);
        end
        repeat (12) do_cycle(1'b0, rtr, rmu, 1'b1);
        chk("scoreboard_drained", mq.size() + rq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
